// File: rtl/crc_seq_ctrl.sv
// Frame sequencer for the nearest-neighbour correction datapath: sweeps the pixel
// index, tracks pipeline latency and emits write strobes/addresses aligned with dataout.
module crc_seq_ctrl #(
    parameter int unsigned NPIX     = 76800,
    parameter int unsigned PIPE_LAT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_abort,
    output logic [17:0] o_cnt,
    output logic        o_wr_en,
    output logic [17:0] o_wr_addr,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned CNT_W  = 18;
    localparam int unsigned WCNT_W = 19;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NPIX - 1);
    localparam logic [WCNT_W-1:0] LAST_WR  = WCNT_W'(NPIX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [WCNT_W-1:0]   r_wr_cnt;
    logic [PIPE_LAT-1:0] r_vpipe;
    logic                r_busy;
    logic                r_done;

    logic w_issue;
    logic w_wr_en;
    logic w_last_wr;

    // Issue decision is made in the current cycle so a pause holds the index on cnt.
    assign w_issue   = (r_state == S_RUN) && !i_pause && !i_abort;
    assign w_wr_en   = r_vpipe[PIPE_LAT-1];
    assign w_last_wr = w_wr_en && (r_wr_cnt == LAST_WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_wr_cnt <= '0;
            r_vpipe  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_abort) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_wr_cnt <= '0;
            r_vpipe  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_vpipe <= PIPE_LAT'({r_vpipe, w_issue});
            if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + WCNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state  <= S_RUN;
                        r_cnt    <= '0;
                        r_wr_cnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    // cnt parks on the last index once the sweep is complete.
                    if (w_issue) begin
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_last_wr) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cnt     = r_cnt;
    assign o_wr_en   = w_wr_en;
    assign o_wr_addr = r_wr_cnt[CNT_W-1:0];
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// Bench for crc_seq_ctrl: table of frame scenarios with a write scoreboard
// (address and cycle of every expected write) plus reset/abort corner sequences.
module tb_crc_seq_ctrl;

    localparam int NPIX     = 16;
    localparam int PIPE_LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_pause, i_abort;
    logic [17:0] o_cnt;
    logic        o_wr_en;
    logic [17:0] o_wr_addr;
    logic        o_busy, o_done;

    crc_seq_ctrl #(.NPIX(NPIX), .PIPE_LAT(PIPE_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_pause   (i_pause),
        .i_abort   (i_abort),
        .o_cnt     (o_cnt),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int cyc;
    } exp_t;

    typedef struct {
        int pause_idx;
        int pause_len;
        int abort_idx;
        int busy_start_idx;
        bit drain_pause;
        bit drain_reset;
        int exp_writes;
        int exp_done_off;
    } vec_t;

    exp_t q[$];
    int   cyc      = 0;
    int   wr_total = 0;
    int   n_vec    = 0;
    int   n_err    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every observed write must match the next expected address and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && o_wr_en === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_wr", 1, 0);
            end else begin
                e = q.pop_front();
                chk("wr_addr", 32'(o_wr_addr), e.addr);
                chk("wr_cycle", cyc, e.cyc);
            end
            wr_total++;
        end
    end

    task automatic run_vec(input vec_t v);
        int run0;
        int base;
        int nd;
        bit aborted;
        aborted = 1'b0;
        q.delete();
        base    = wr_total;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        run0    = cyc;
        for (int k = 0; k < NPIX; k++) begin
            chk("cnt", 32'(o_cnt), k);
            chk("busy_run", 32'(o_busy), 1);
            if (k == v.abort_idx) begin
                i_abort = 1'b1;
                step();
                i_abort = 1'b0;
                chk("abort_busy", 32'(o_busy), 0);
                chk("abort_wr_en", 32'(o_wr_en), 0);
                chk("abort_cnt", 32'(o_cnt), 0);
                q.delete();
                aborted = 1'b1;
                break;
            end
            if (k == v.pause_idx) begin
                i_pause = 1'b1;
                for (int p = 0; p < v.pause_len; p++) begin
                    step();
                    chk("pause_cnt", 32'(o_cnt), k);
                end
                i_pause = 1'b0;
            end
            if (k == v.busy_start_idx) i_start = 1'b1;
            q.push_back('{k, cyc + PIPE_LAT});
            step();
            i_start = 1'b0;
        end

        if (aborted) begin
            nd = 0;
            repeat (12) begin
                step();
                if (o_done) nd++;
            end
            chk("abort_no_done", nd, 0);
        end else if (v.drain_reset) begin
            step();
            step();
            rst_n = 1'b0;
            #1;
            chk("rst_cnt", 32'(o_cnt), 0);
            chk("rst_wr_en", 32'(o_wr_en), 0);
            chk("rst_wr_addr", 32'(o_wr_addr), 0);
            chk("rst_busy", 32'(o_busy), 0);
            chk("rst_done", 32'(o_done), 0);
            q.delete();
            #1;
            rst_n = 1'b1;
            nd = 0;
            repeat (5) begin
                step();
                if (o_busy || o_done) nd++;
            end
            chk("rst_stays_idle", nd, 0);
            chk("rst_idle_cnt", 32'(o_cnt), 0);
        end else begin
            chk("busy_drain", 32'(o_busy), 1);
            i_pause = v.drain_pause;
            for (int w = 0; w < 40; w++) begin
                if (o_done) break;
                step();
            end
            chk("done_seen", 32'(o_done), 1);
            if (o_done) begin
                chk("done_offset", cyc - run0, v.exp_done_off);
                chk("done_busy", 32'(o_busy), 0);
            end
            i_pause = 1'b0;
            step();
            chk("done_pulse", 32'(o_done), 0);
        end
        chk("writes", wr_total - base, v.exp_writes);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{-1, 0, -1, -1, 1'b0, 1'b0, 16, 21};
        tbl[1] = '{-1, 0, -1, -1, 1'b0, 1'b0, 16, 21};
        tbl[2] = '{ 5, 3, -1, -1, 1'b0, 1'b0, 16, 24};
        tbl[3] = '{-1, 0,  9, -1, 1'b0, 1'b0,  5, -1};
        tbl[4] = '{-1, 0, -1, -1, 1'b0, 1'b0, 16, 21};
        tbl[5] = '{-1, 0, -1,  3, 1'b1, 1'b0, 16, 21};
        tbl[6] = '{ 0, 2, -1, -1, 1'b0, 1'b0, 16, 23};
        tbl[7] = '{15, 1, -1, -1, 1'b0, 1'b0, 16, 22};
        tbl[8] = '{-1, 0, -1, -1, 1'b0, 1'b1, 13, -1};
        tbl[9] = '{-1, 0, -1, -1, 1'b0, 1'b0, 16, 21};

        rst_n   = 1'b0;
        i_start = 1'b0;
        i_pause = 1'b0;
        i_abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cnt", 32'(o_cnt), 0);
        chk("reset_wr_en", 32'(o_wr_en), 0);
        chk("reset_wr_addr", 32'(o_wr_addr), 0);
        chk("reset_busy", 32'(o_busy), 0);
        chk("reset_done", 32'(o_done), 0);
        #2;
        rst_n = 1'b1;
        step();

        // start together with abort in IDLE must be ignored
        i_start = 1'b1;
        i_abort = 1'b1;
        step();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("start_abort_busy", 32'(o_busy), 0);
        step();
        chk("start_abort_busy2", 32'(o_busy), 0);
        chk("start_abort_cnt", 32'(o_cnt), 0);
        chk("start_abort_wr_en", 32'(o_wr_en), 0);

        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i]);
        end

        repeat (3) step();
        chk("final_queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
